// File: rtl/mux_scan_arb_pkg.sv
// Shared constants, state encoding and helpers for the scanning mux arbiter.
package mux_scan_arb_pkg;

    localparam int unsigned NumCh = 4;
    localparam int unsigned SelW  = 2;

    typedef logic [1:0] state_t;

    localparam state_t StIdle = 2'd0;
    localparam state_t StSel  = 2'd1;
    localparam state_t StHold = 2'd2;

    function automatic logic [NumCh-1:0] chan_onehot(input logic [SelW-1:0] ch);
        chan_onehot = '0;
        chan_onehot[ch] = 1'b1;
    endfunction

endpackage

// File: rtl/mux_scan_arb_if.sv
// Request / mux-select / output-word bundle between the arbiter and its environment.
interface mux_scan_arb_if
    import mux_scan_arb_pkg::*;
#(
    parameter int unsigned N = 4
);
    logic [NumCh-1:0] REQ;
    logic [SelW-1:0]  S;
    logic [N-1:0]     Y;
    logic [NumCh-1:0] GNT;
    logic [N-1:0]     DOUT;
    logic [SelW-1:0]  DOUT_CH;
    logic             DOUT_VALID;
    logic             DOUT_READY;

    // Arbiter side: drives the external mux select and the captured word.
    modport master (
        input  REQ, Y, DOUT_READY,
        output S, GNT, DOUT, DOUT_CH, DOUT_VALID
    );

    modport slave (
        output REQ, Y, DOUT_READY,
        input  S, GNT, DOUT, DOUT_CH, DOUT_VALID
    );
endinterface

// File: rtl/mux_scan_arb_rr_pick.sv
// Combinational round-robin pick: first set request scanning ptr, ptr+1, ... (mod 4).
module rr_pick
    import mux_scan_arb_pkg::*;
(
    input  logic [NumCh-1:0] req,
    input  logic [SelW-1:0]  ptr,
    output logic [SelW-1:0]  winner,
    output logic             any_req
);
    logic [SelW-1:0] idx;

    // Scan from the farthest offset down so the nearest set bit to ptr wins last.
    always_comb begin
        winner  = ptr;
        any_req = 1'b0;
        idx     = '0;
        for (int k = NumCh - 1; k >= 0; k--) begin
            idx = ptr + k[SelW-1:0];
            if (req[idx]) begin
                winner  = idx;
                any_req = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mux_scan_arb.sv
// Round-robin arbiter that steers an external 4:1 mux and captures one word per grant.
module mux_scan_arb
    import mux_scan_arb_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input logic            CLK,
    input logic            RST,
    mux_scan_arb_if.master bus
);
    state_t           state_q, state_d;
    logic [SelW-1:0]  ptr_q, ptr_d;
    logic [SelW-1:0]  s_q, s_d;
    logic [SelW-1:0]  ch_q, ch_d;
    logic [NumCh-1:0] gnt_q, gnt_d;
    logic [N-1:0]     dout_q, dout_d;
    logic             valid_q, valid_d;
    logic [SelW-1:0]  winner;
    logic             any_req;

    rr_pick u_rr_pick (
        .req     (bus.REQ),
        .ptr     (ptr_q),
        .winner  (winner),
        .any_req (any_req)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        s_d     = s_q;
        ch_d    = ch_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        gnt_d   = '0;
        case (state_q)
            StIdle: begin
                if (any_req) begin
                    s_d     = winner;
                    state_d = StSel;
                end
            end
            StSel: begin
                // S has been stable for a full cycle, so Y reflects the winner.
                dout_d  = bus.Y;
                ch_d    = s_q;
                valid_d = 1'b1;
                gnt_d   = chan_onehot(s_q);
                ptr_d   = s_q + SelW'(1);
                state_d = StHold;
            end
            StHold: begin
                if (valid_q && bus.DOUT_READY) begin
                    valid_d = 1'b0;
                    if (any_req) begin
                        s_d     = winner;
                        state_d = StSel;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            s_q     <= '0;
            ch_q    <= '0;
            gnt_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            s_q     <= s_d;
            ch_q    <= ch_d;
            gnt_q   <= gnt_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
        end
    end

    assign bus.S          = s_q;
    assign bus.GNT        = gnt_q;
    assign bus.DOUT       = dout_q;
    assign bus.DOUT_CH    = ch_q;
    assign bus.DOUT_VALID = valid_q;
endmodule

// File: tb/tb_mux_scan_arb.sv
// Directed and randomized checks of mux_scan_arb against a per-cycle behavioural model.
module tb_mux_scan_arb;
    localparam int N = 4;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic [N-1:0] mux_data [4];

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: phase 0 = waiting for requests, 1 = select settling, 2 = holding a word.
    int           m_phase;
    int           m_ptr;
    int           m_s;
    logic [3:0]   m_gnt;
    logic [N-1:0] m_dout;
    int           m_ch;
    logic         m_valid;

    int gnt_seq[$];
    int gnt_cyc[$];
    int cyc_no;

    mux_scan_arb_if #(.N(N)) bus ();

    mux_scan_arb #(.N(N)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    assign bus.Y = mux_data[bus.S];

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    function automatic int oh2idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v == (4'b1 << i)) return i;
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (RST) begin
            m_phase = 0; m_ptr = 0; m_s = 0; m_gnt = '0;
            m_dout = '0; m_ch = 0; m_valid = 1'b0;
            return;
        end
        m_gnt = '0;
        if (m_phase == 0) begin
            if (bus.REQ != 0) begin
                m_s = pick(bus.REQ, m_ptr);
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_dout  = mux_data[m_s];
            m_ch    = m_s;
            m_valid = 1'b1;
            m_gnt   = 4'b1 << m_s;
            m_ptr   = (m_s + 1) % 4;
            m_phase = 2;
        end else if (bus.DOUT_READY) begin
            m_valid = 1'b0;
            if (bus.REQ != 0) begin
                m_s = pick(bus.REQ, m_ptr);
                m_phase = 1;
            end else begin
                m_phase = 0;
            end
        end
    endtask

    task automatic cyc();
        model_edge();
        @(posedge CLK);
        #1;
        cyc_no++;
        check("S", 32'(bus.S), 32'(m_s));
        check("GNT", 32'(bus.GNT), 32'(m_gnt));
        check("DOUT_VALID", 32'(bus.DOUT_VALID), 32'(m_valid));
        check("DOUT", 32'(bus.DOUT), 32'(m_dout));
        check("DOUT_CH", 32'(bus.DOUT_CH), 32'(m_ch));
        if (bus.GNT != 0) begin
            gnt_seq.push_back(oh2idx(bus.GNT));
            gnt_cyc.push_back(cyc_no);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        gnt_seq.delete();
        gnt_cyc.delete();
    endtask

    initial begin
        logic [N-1:0] held_dout;
        logic [1:0]   held_ch;
        logic [1:0]   held_s;
        int exp_ch [5] = '{0, 1, 2, 3, 0};

        mux_data[0] = 4'b0010;
        mux_data[1] = 4'b0110;
        mux_data[2] = 4'b1010;
        mux_data[3] = 4'b0011;
        cyc_no = 0;
        bus.REQ = 4'b0000;
        bus.DOUT_READY = 1'b0;

        // Reset state.
        do_reset();
        check("rst_valid", 32'(bus.DOUT_VALID), 32'd0);
        check("rst_s", 32'(bus.S), 32'd0);
        check("rst_gnt", 32'(bus.GNT), 32'd0);

        // Single request on channel C.
        bus.REQ = 4'b0100;
        bus.DOUT_READY = 1'b1;
        cyc();
        check("single_s", 32'(bus.S), 32'd2);
        check("single_valid_early", 32'(bus.DOUT_VALID), 32'd0);
        bus.REQ = 4'b0000;
        cyc();
        check("single_dout", 32'(bus.DOUT), 32'b1010);
        check("single_ch", 32'(bus.DOUT_CH), 32'd2);
        check("single_valid", 32'(bus.DOUT_VALID), 32'd1);
        check("single_gnt", 32'(bus.GNT), 32'b0100);

        // Idle: no requests for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (i > 0) begin
                check("idle_valid", 32'(bus.DOUT_VALID), 32'd0);
                check("idle_gnt", 32'(bus.GNT), 32'd0);
                check("idle_s", 32'(bus.S), 32'd2);
            end
        end

        // Fairness with all channels requesting.
        do_reset();
        bus.REQ = 4'b1111;
        bus.DOUT_READY = 1'b1;
        for (int i = 0; i < 10; i++) cyc();
        check("fair_count", 32'(gnt_seq.size()), 32'd5);
        for (int i = 0; i < 5 && i < gnt_seq.size(); i++) begin
            check("fair_ch", 32'(gnt_seq[i]), 32'(exp_ch[i]));
            if (i > 0) check("fair_spacing", 32'(gnt_cyc[i] - gnt_cyc[i-1]), 32'd2);
        end
        check("fair_last_dout", 32'(bus.DOUT), 32'b0010);

        // Backpressure: hold the word for 5 cycles.
        bus.DOUT_READY = 1'b0;
        held_dout = bus.DOUT;
        held_ch   = bus.DOUT_CH;
        held_s    = bus.S;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("bp_dout", 32'(bus.DOUT), 32'(held_dout));
            check("bp_ch", 32'(bus.DOUT_CH), 32'(held_ch));
            check("bp_s", 32'(bus.S), 32'(held_s));
            check("bp_gnt", 32'(bus.GNT), 32'd0);
            check("bp_valid", 32'(bus.DOUT_VALID), 32'd1);
        end
        bus.REQ = 4'b0000;
        bus.DOUT_READY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("bp_consumed_once", 32'(bus.DOUT_VALID), 32'd0);
        end

        // Wrap and skip: grant C, then A, then B.
        do_reset();
        bus.REQ = 4'b0100;
        cyc();
        bus.REQ = 4'b0011;
        for (int i = 0; i < 5; i++) cyc();
        check("wrap_count", 32'(gnt_seq.size()), 32'd3);
        if (gnt_seq.size() == 3) begin
            check("wrap_g0", 32'(gnt_seq[0]), 32'd2);
            check("wrap_g1", 32'(gnt_seq[1]), 32'd0);
            check("wrap_g2", 32'(gnt_seq[2]), 32'd1);
        end

        // Reset while holding a word.
        bus.REQ = 4'b1111;
        bus.DOUT_READY = 1'b0;
        for (int i = 0; i < 3; i++) cyc();
        check("mid_in_hold", 32'(bus.DOUT_VALID), 32'd1);
        bus.REQ = 4'b1000;
        do_reset();
        check("mid_valid", 32'(bus.DOUT_VALID), 32'd0);
        check("mid_s", 32'(bus.S), 32'd0);
        check("mid_gnt", 32'(bus.GNT), 32'd0);
        bus.DOUT_READY = 1'b1;
        cyc();
        cyc();
        check("mid_first_gnt", 32'(bus.GNT), 32'b1000);
        check("mid_first_dout", 32'(bus.DOUT), 32'b0011);

        // Randomized traffic with occasional reset.
        bus.REQ = 4'b0000;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            bus.REQ = 4'($urandom_range(0, 15));
            bus.DOUT_READY = ($urandom_range(0, 3) != 0);
            RST = ($urandom_range(0, 59) == 0);
            if (i % 50 == 0) begin
                for (int c = 0; c < 4; c++) mux_data[c] = 4'($urandom);
            end
            cyc();
        end
        RST = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mux_scan_arb.md
MUX_SCAN_ARB -- requirements
Module: mux_scan_arb

Interface
REQ-001 SHALL have parameter N, default 4, meaning data width of the upstream multiplexer channels.
REQ-002 SHALL have port CLK, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST, input, 1, meaning reset, synchronous and active-high.
REQ-004 SHALL have port REQ, input, 4, meaning per-channel request; bit k = channel k (A=0, B=1, C=2, D=3) has data ready.
REQ-005 SHALL have port S, output, 2, meaning select driven to the N-bit 4:1 multiplexer.
REQ-006 SHALL have port Y, input, N, meaning the multiplexer output, combinationally dependent on S.
REQ-007 SHALL have port GNT, output, 4, meaning one-hot, single-cycle acknowledge to the channel whose data was captured.
REQ-008 SHALL have port DOUT, output, N, meaning the captured channel word.
REQ-009 SHALL have port DOUT_CH, output, 2, meaning the channel index of DOUT.
REQ-010 SHALL have port DOUT_VALID, output, 1, meaning DOUT/DOUT_CH hold a word.
REQ-011 SHALL have port DOUT_READY, input, 1, meaning the downstream consumer accepts the word.

Function
REQ-012 SHALL implement the states IDLE, SEL and HOLD.
REQ-013 In IDLE with REQ=0, the block SHALL remain in IDLE, S holding its last value.
REQ-014 In IDLE with REQ!=0, the block SHALL pick a winner round-robin from the priority pointer PTR, load S=winner and move to SEL.
REQ-015 Round-robin SHALL scan PTR, PTR+1, PTR+2, PTR+3 (mod 4), and the first set REQ bit SHALL win.
REQ-016 In SEL, the block SHALL register DOUT<=Y, DOUT_CH<=S and DOUT_VALID<=1, SHALL assert GNT[S] for exactly that cycle, SHALL set PTR<=S+1 (mod 4) and SHALL move to HOLD.
REQ-017 The latency from REQ sampled in IDLE to DOUT_VALID high SHALL be 2 cycles.
REQ-018 In HOLD, DOUT, DOUT_CH and DOUT_VALID SHALL stay stable until DOUT_VALID and DOUT_READY are both high on a clock edge.
REQ-019 On that accepting edge, if REQ!=0, the block SHALL clear DOUT_VALID, arbitrate with the updated PTR, load S and go directly to SEL.
REQ-020 On that accepting edge, if REQ=0, the block SHALL clear DOUT_VALID and go to IDLE.
REQ-021 Sustained throughput SHALL be one word per 2 cycles when DOUT_READY is held high and REQ is held nonzero.
REQ-022 DOUT_READY while DOUT_VALID=0 SHALL have no effect.
REQ-023 REQ changes during SEL or HOLD SHALL NOT alter the current capture, and the winner SHALL be decided only at arbitration edges.
REQ-024 A REQ bit that drops before it wins SHALL simply be skipped, with no error state.
REQ-025 PTR wrap-around SHALL be modulo 4, so a grant to channel 3 gives PTR=0.
REQ-026 GNT SHALL be 0 in every state except SEL.
REQ-027 S SHALL change only on arbitration edges (IDLE->SEL or HOLD->SEL).

Reset
REQ-028 RST=1 on a clock edge SHALL force state=IDLE, PTR=0, S=0, GNT=0, DOUT=0, DOUT_CH=0 and DOUT_VALID=0, overriding every other input.
REQ-029 A reset during SEL or HOLD SHALL discard the in-flight word, with no GNT pulse on the reset edge.
REQ-030 The first arbitration after reset release SHALL evaluate channel 0 first.

Structure
REQ-031 A shared package SHALL hold the state enumeration (IDLE, SEL, HOLD), the channel-count constant (4) and the select-width constant (2).
REQ-032 A sub-module rr_pick SHALL be used, purely combinational, taking REQ[3:0] and PTR[1:0] and producing winner[1:0] and any_req.
REQ-033 The block SHALL contain no multiplexer of its own; it SHALL drive S to, and read Y from, the existing N-bit mux instance.

Verification
REQ-034 Single request: N=4, mux data A=0010, B=0110, C=1010, D=0011, REQ=0100, DOUT_READY=1 -> S=10 on the next cycle; DOUT=1010, DOUT_CH=10, DOUT_VALID=1 and GNT=0100 two cycles after REQ.
REQ-035 Fairness: REQ=1111 held, DOUT_READY=1 -> DOUT_CH sequence 00, 01, 10, 11, 00 with DOUT sequence 0010, 0110, 1010, 0011, 0010, one word every 2 cycles.
REQ-036 Backpressure: DOUT_READY=0 for 5 cycles with DOUT_VALID=1 -> DOUT, DOUT_CH and S stable and GNT=0 throughout; on DOUT_READY=1 the word is consumed once only.
REQ-037 Wrap and skip: PTR=3 after granting channel 2, REQ=0011 -> next grant is channel 0, then channel 1.
REQ-038 Mid-operation reset: RST=1 asserted in HOLD -> next cycle DOUT_VALID=0, S=00 and GNT=0; after release with REQ=1000, the first grant is channel 3 (scan from 0).
REQ-039 Idle: REQ=0 for 10 cycles -> DOUT_VALID=0, GNT=0 and S unchanged.
